// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

  // FSM state encodings (2-bit, legacy-compatible values)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module seq_divider_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             a_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] r_sub;

  // Shift/compare/subtract; r_in < d always holds, so r_sh fits WIDTH+1 bits
  always_comb begin
    r_sh  = {r_in, a_msb};
    r_sub = r_sh - {1'b0, d};
    if (r_sh >= {1'b0, d}) begin
      r_out = r_sub[WIDTH-1:0];
      q_bit = 1'b1;
    end else begin
      r_out = r_sh[WIDTH-1:0];
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider (signed/unsigned), one quotient bit per clock.
// Fixed latency: accept at edge N, done high in cycle N+WIDTH+2.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_a_q, acc_a_d;      // dividend magnitude, shifted out MSB-first
  logic [WIDTH-1:0] rem_acc_q, rem_acc_d;  // partial remainder
  logic [WIDTH-1:0] quo_acc_q, quo_acc_d;  // quotient magnitude, shifted in LSB-first
  logic [WIDTH-1:0] dvs_q, dvs_d;          // divisor magnitude
  logic [WIDTH-1:0] dvd_q, dvd_d;          // original dividend for special cases
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_flag_q, dz_flag_d;
  logic             ov_flag_q, ov_flag_d;

  logic [WIDTH-1:0] step_r;
  logic             step_q;
  logic             a_neg, b_neg;

  seq_divider_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (rem_acc_q),
    .a_msb (acc_a_q[WIDTH-1]),
    .d     (dvs_q),
    .r_out (step_r),
    .q_bit (step_q)
  );

  // Next-state and datapath logic for the IDLE/CALC/FIX/DONE sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_a_d   = acc_a_q;
    rem_acc_d = rem_acc_q;
    quo_acc_d = quo_acc_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ov_d      = ov_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dz_flag_d = dz_flag_q;
    ov_flag_d = ov_flag_q;
    a_neg     = is_signed & dividend[WIDTH-1];
    b_neg     = is_signed & divisor[WIDTH-1];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CALC;
          cnt_d     = CNT_W'(WIDTH);
          acc_a_d   = a_neg ? -dividend : dividend;
          dvs_d     = b_neg ? -divisor : divisor;
          rem_acc_d = '0;
          quo_acc_d = '0;
          dvd_d     = dividend;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = (divisor == '0);
          ov_d      = is_signed && (dividend == MIN_NEG) && (divisor == '1);
          dz_flag_d = 1'b0;
          ov_flag_d = 1'b0;
        end
      end
      S_CALC: begin
        rem_acc_d = step_r;
        acc_a_d   = acc_a_q << 1;
        quo_acc_d = {quo_acc_q[WIDTH-2:0], step_q};
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d   = S_DONE;
        quo_d     = neg_quo_q ? -quo_acc_q : quo_acc_q;
        rem_d     = neg_rem_q ? -rem_acc_q : rem_acc_q;
        // Special cases override the iterated result but keep the fixed latency
        if (dz_q) begin
          quo_d = '1;
          rem_d = dvd_q;
        end else if (ov_q) begin
          quo_d = dvd_q;
          rem_d = '0;
        end
        dz_flag_d = dz_q;
        ov_flag_d = ov_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_a_q   <= '0;
      rem_acc_q <= '0;
      quo_acc_q <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dz_flag_q <= 1'b0;
      ov_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_a_q   <= acc_a_d;
      rem_acc_q <= rem_acc_d;
      quo_acc_q <= quo_acc_d;
      dvs_q     <= dvs_d;
      dvd_q     <= dvd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ov_q      <= ov_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dz_flag_q <= dz_flag_d;
      ov_flag_q <= ov_flag_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_flag_q;
  assign overflow    = ov_flag_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks for seq_divider at WIDTH=16.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Runs one operation starting in the current (negedge-aligned) cycle 0.
  // Returns the cycle in which done was seen (-1 on timeout) and the outputs then.
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output logic ov, output int cyc);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    ov = overflow;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0)
      $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, need all 0",
               busy, done, quotient, remainder, div_by_zero, overflow);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timing();
    int bad_busy = 0;
    int done_cyc = -1;
    logic [W-1:0] q_at, r_at;
    logic dz_at, ov_at;
    is_signed = 1'b0; dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== ((k >= 1) && (k <= 18))) bad_busy++;
      if (done === 1'b1) begin
        if (done_cyc < 0) done_cyc = k;
        q_at = quotient; r_at = remainder; dz_at = div_by_zero; ov_at = overflow;
      end
    end
    total_cnt++;
    if (bad_busy != 0) $display("FAIL busy_window: %0d cycles wrong, need busy in 1..18 only", bad_busy);
    else pass_cnt++;
    total_cnt++;
    if (done_cyc != 18) $display("FAIL done_latency: got cycle %0d, need 18", done_cyc);
    else pass_cnt++;
    total_cnt++;
    if ({q_at, r_at, dz_at, ov_at} !== {16'd14, 16'd2, 1'b0, 1'b0})
      $display("FAIL udiv_100_7: got q=%0d r=%0d dz=%b ov=%b, need q=14 r=2 dz=0 ov=0",
               q_at, r_at, dz_at, ov_at);
    else pass_cnt++;
  endtask

  task automatic test_signs();
    logic         s_v [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] a_v [4] = '{16'hFFF9, 16'h0007, 16'hFFF9, 16'hFFF9};
    logic [W-1:0] b_v [4] = '{16'h0002, 16'hFFFE, 16'h0002, 16'hFFFE};
    logic [W-1:0] q_v [4] = '{16'hFFFD, 16'hFFFD, 16'h7FFC, 16'h0003};
    logic [W-1:0] r_v [4] = '{16'hFFFF, 16'h0001, 16'h0001, 16'hFFFF};
    logic [W-1:0] q, r;
    logic dz, ov;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      do_op(s_v[i], a_v[i], b_v[i], q, r, dz, ov, cyc);
      total_cnt++;
      if ({q, r, dz, ov} !== {q_v[i], r_v[i], 2'b00} || cyc != 18)
        $display("FAIL sign_case_%0d: got q=%h r=%h dz=%b ov=%b cyc=%0d, need q=%h r=%h dz=0 ov=0 cyc=18",
                 i, q, r, dz, ov, cyc, q_v[i], r_v[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r;
    logic dz, ov;
    int cyc;
    for (int m = 0; m < 2; m++) begin
      do_op(m[0], 16'd1234, 16'd0, q, r, dz, ov, cyc);
      total_cnt++;
      if ({q, r, dz, ov} !== {16'hFFFF, 16'd1234, 1'b1, 1'b0} || cyc != 18)
        $display("FAIL div_zero_mode%0d: got q=%h r=%0d dz=%b ov=%b cyc=%0d, need q=ffff r=1234 dz=1 ov=0 cyc=18",
                 m, q, r, dz, ov, cyc);
      else pass_cnt++;
    end
    do_op(1'b1, 16'hFFFB, 16'd0, q, r, dz, ov, cyc);
    total_cnt++;
    if ({q, r, dz, ov} !== {16'hFFFF, 16'hFFFB, 1'b1, 1'b0})
      $display("FAIL div_zero_neg: got q=%h r=%h dz=%b ov=%b, need q=ffff r=fffb dz=1 ov=0",
               q, r, dz, ov);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [W-1:0] q, r;
    logic dz, ov;
    int cyc;
    do_op(1'b1, 16'h8000, 16'hFFFF, q, r, dz, ov, cyc);
    total_cnt++;
    if ({q, r, dz, ov} !== {16'h8000, 16'h0000, 1'b0, 1'b1} || cyc != 18)
      $display("FAIL ovf_signed: got q=%h r=%h dz=%b ov=%b cyc=%0d, need q=8000 r=0 dz=0 ov=1 cyc=18",
               q, r, dz, ov, cyc);
    else pass_cnt++;
    do_op(1'b0, 16'h8000, 16'hFFFF, q, r, dz, ov, cyc);
    total_cnt++;
    if ({q, r, dz, ov} !== {16'h0000, 16'h8000, 1'b0, 1'b0})
      $display("FAIL ovf_unsigned: got q=%h r=%h dz=%b ov=%b, need q=0 r=8000 dz=0 ov=0",
               q, r, dz, ov);
    else pass_cnt++;
  endtask

  task automatic test_ignored_start();
    logic [W-1:0] q18, r18;
    int done18 = 0;
    int late_busy = 0;
    is_signed = 1'b0; dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 18) begin done18 = done; q18 = quotient; r18 = remainder; end
      if (k >= 19 && (busy !== 1'b0 || done !== 1'b0)) late_busy++;
      if (k == 5 || k == 18) begin
        start = 1'b1; is_signed = 1'b1; dividend = 16'hFFF9; divisor = 16'd3;
      end else begin
        start = 1'b0;
      end
    end
    total_cnt++;
    if (done18 != 1 || q18 !== 16'd14 || r18 !== 16'd2)
      $display("FAIL start_while_busy: got done=%0d q=%0d r=%0d at cycle 18, need done=1 q=14 r=2",
               done18, q18, r18);
    else pass_cnt++;
    total_cnt++;
    if (late_busy != 0)
      $display("FAIL start_in_done: got %0d busy/done cycles after 18, need 0", late_busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] q, r;
    logic dz, ov;
    int cyc;
    int early_done = 0;
    is_signed = 1'b1; dividend = 16'h0007; divisor = 16'hFFFE; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) early_done++;
      if (k == 9) rst_n = 1'b0;
    end
    total_cnt++;
    if (early_done != 0 || {busy, done, quotient, remainder, div_by_zero, overflow} !== '0)
      $display("FAIL reset_abort: got early_done=%0d busy=%b done=%b q=%h r=%h dz=%b ov=%b, need all 0",
               early_done, busy, done, quotient, remainder, div_by_zero, overflow);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b0, 16'd100, 16'd7, q, r, dz, ov, cyc);
    total_cnt++;
    if (q !== 16'd14 || r !== 16'd2 || cyc != 18)
      $display("FAIL after_abort: got q=%0d r=%0d cyc=%0d, need q=14 r=2 cyc=18", q, r, cyc);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r, eq, er;
    logic signed [W-1:0] sa, sb;
    logic dz, ov, edz, eov, s;
    int cyc;
    int errs = 0;
    for (int i = 0; i < 3000; i++) begin
      s = i[0];
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = W'($urandom_range(0, 9));
        1:       b = -W'($urandom_range(1, 9));
        default: b = W'($urandom);
      endcase
      if (i % 500 == 2) begin a = 16'h8000; b = 16'hFFFF; end
      sa = a; sb = b;
      edz = 1'b0; eov = 1'b0;
      if (b == '0) begin
        eq = '1; er = a; edz = 1'b1;
      end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
        eq = a; er = '0; eov = 1'b1;
      end else if (s) begin
        eq = sa / sb; er = sa % sb;
      end else begin
        eq = a / b; er = a % b;
      end
      do_op(s, a, b, q, r, dz, ov, cyc);
      total_cnt++;
      if ({q, r, dz, ov} !== {eq, er, edz, eov} || cyc != 18) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random_%0d: s=%b %h/%h got q=%h r=%h dz=%b ov=%b cyc=%0d, need q=%h r=%h dz=%b ov=%b cyc=18",
                   i, s, a, b, q, r, dz, ov, cyc, eq, er, edz, eov);
      end else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_signs();
    test_div_zero();
    test_overflow();
    test_ignored_start();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
